color_tracker: RTL and testbench



---
 rtl/color_tracker_pkg.sv | 34 +++
 rtl/color_tracker_div.sv | 88 ++++++++
 rtl/color_tracker.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_color_tracker.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_tracker_pkg.sv
// -----------------------------------------------------------------------------
// color_tracker_pkg
// Shared definitions for the colour tracker: default widths, accumulator
// widths, the tracker FSM state type and the U/V absolute-difference helper.
// Optional feature macro used by the tracker: TRACK_BBOX_EN (bounding box).
// -----------------------------------------------------------------------------
package color_tracker_pkg;

    localparam int DEF_ROW_W     = 13;
    localparam int DEF_COL_W     = 13;
    localparam int DEF_CNT_W     = 21;
    localparam int DEF_MIN_COUNT = 16;

    // Coordinate sums must hold (max coordinate) * (max count) without wrap.
    localparam int SUM_ROW_W = DEF_ROW_W + DEF_CNT_W;
    localparam int SUM_COL_W = DEF_COL_W + DEF_CNT_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DIVIDE = 2'd2,
        DONE   = 2'd3
    } state_e;

    // |a - b| for two signed 9-bit chroma values. The subtraction is done at
    // 10 bits after sign extension, so the range -511..511 never overflows.
    function automatic logic [9:0] abs_diff9(input logic signed [8:0] a,
                                             input logic signed [8:0] b);
        logic [9:0] d;
        d = {a[8], a} - {b[8], b};
        return d[9] ? (~d + 10'd1) : d;
    endfunction

endpackage

// File: rtl/color_tracker_div.sv
// -----------------------------------------------------------------------------
// seq_divider
// Restoring unsigned divider producing one quotient bit per clock.
// A start pulse loads dividend/divisor; the division then takes DW cycles.
// done is high during the final iteration cycle and stays high afterwards
// until the next start, so two dividers of different widths can be joined.
// The quotient register holds the full result on the cycle after the last
// iteration.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               load operands and begin
//   dividend [DW-1:0]   numerator
//   divisor  [VW-1:0]   denominator (must be non-zero)
//   quotient [QW-1:0]   low QW bits of the quotient
//   done                division finishing / finished
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int DW = 34,
    parameter int VW = 21,
    parameter int QW = 13
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [QW-1:0] quotient,
    output logic          done
);
    localparam int CW = $clog2(DW + 1);

    // work_q shifts the dividend out at the top and the quotient in at the bottom.
    logic [DW-1:0] work_q, work_d;
    logic [VW-1:0] rem_q, rem_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fin_q, fin_d;
    logic [VW:0]   rem_shift;

    always_comb begin
        work_d    = work_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        fin_d     = fin_q;
        rem_shift = {rem_q, work_q[DW-1]};
        if (start) begin
            work_d = dividend;
            rem_d  = '0;
            dvs_d  = divisor;
            cnt_d  = CW'(DW);
            fin_d  = 1'b0;
        end else if (cnt_q != '0) begin
            if (rem_shift >= {1'b0, dvs_q}) begin
                // True difference is below the divisor, so VW bits suffice.
                rem_d  = rem_shift[VW-1:0] - dvs_q;
                work_d = {work_q[DW-2:0], 1'b1};
            end else begin
                rem_d  = rem_shift[VW-1:0];
                work_d = {work_q[DW-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                fin_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            work_q <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            fin_q  <= 1'b0;
        end else begin
            work_q <= work_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            fin_q  <= fin_d;
        end
    end

    assign quotient = work_q[QW-1:0];
    assign done     = (cnt_q == CW'(1)) || fin_q;

endmodule

// File: rtl/color_tracker.sv
// -----------------------------------------------------------------------------
// color_tracker
// Classifies live YUV pixels against a calibrated reference colour, counts
// matches and sums their coordinates per frame, and at frame end divides the
// sums by the count to produce the object centroid.
// Optional feature: define TRACK_BBOX_EN to track a per-frame bounding box;
// otherwise min_row/max_row/min_col/max_col are tied to 0.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cal_valid, ref_Y/ref_U/ref_V    reference colour load
//   tol_uv, y_min                   match tolerance / luma floor
//   pix_valid, Y_in/U_in/V_in       pixel stream
//   row, col, frame_end             pixel coordinates, end-of-frame strobe
//   match                           registered per-pixel match flag
//   busy                            centroid division in progress
//   result_valid                    one-cycle pulse when results update
//   found, count                    object found flag, match count
//   cent_row, cent_col              centroid
//   min_row/max_row/min_col/max_col bounding box
// -----------------------------------------------------------------------------
module color_tracker
    import color_tracker_pkg::*;
#(
    parameter int ROW_W     = DEF_ROW_W,
    parameter int COL_W     = DEF_COL_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int MIN_COUNT = DEF_MIN_COUNT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cal_valid,
    input  logic [7:0]              ref_Y,
    input  logic signed [8:0]       ref_U,
    input  logic signed [8:0]       ref_V,
    input  logic [7:0]              tol_uv,
    input  logic [7:0]              y_min,
    input  logic                    pix_valid,
    input  logic [7:0]              Y_in,
    input  logic signed [8:0]       U_in,
    input  logic signed [8:0]       V_in,
    input  logic [ROW_W-1:0]        row,
    input  logic [COL_W-1:0]        col,
    input  logic                    frame_end,
    output logic                    match,
    output logic                    busy,
    output logic                    result_valid,
    output logic                    found,
    output logic [CNT_W-1:0]        count,
    output logic [ROW_W-1:0]        cent_row,
    output logic [COL_W-1:0]        cent_col,
    output logic [ROW_W-1:0]        min_row,
    output logic [ROW_W-1:0]        max_row,
    output logic [COL_W-1:0]        min_col,
    output logic [COL_W-1:0]        max_col
);
    localparam int SROW_W = ROW_W + CNT_W;
    localparam int SCOL_W = COL_W + CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // The luma gate is the absolute floor y_min; the calibrated luma is part of
    // the calibration interface but does not enter the match rule.
    logic unused_ref_y;
    assign unused_ref_y = ^ref_Y;

    state_e state_q, state_d;

    logic signed [8:0] ref_u_q, ref_v_q;
    logic              ref_valid_q;

    // Registered pixel stage: classification result plus its coordinates.
    logic              match_q, match_d;
    logic [ROW_W-1:0]  prow_q;
    logic [COL_W-1:0]  pcol_q;
    logic              fe_q;

    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic [SROW_W-1:0] srow_q, srow_d;
    logic [SCOL_W-1:0] scol_q, scol_d;
    logic              acc_en;

    logic              div_start, row_done, col_done;
    logic [ROW_W-1:0]  q_row;
    logic [COL_W-1:0]  q_col;
    logic              found_now;

    logic              result_valid_q, found_q;
    logic [CNT_W-1:0]  count_q;
    logic [ROW_W-1:0]  cent_row_q;
    logic [COL_W-1:0]  cent_col_q;

    // ---------------- classification ----------------
    always_comb begin
        match_d = (state_q == ACCUM) && pix_valid && ref_valid_q
               && (abs_diff9(U_in, ref_u_q) <= {2'b00, tol_uv})
               && (abs_diff9(V_in, ref_v_q) <= {2'b00, tol_uv})
               && (Y_in >= y_min);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ref_u_q     <= '0;
            ref_v_q     <= '0;
            ref_valid_q <= 1'b0;
            match_q     <= 1'b0;
            prow_q      <= '0;
            pcol_q      <= '0;
            fe_q        <= 1'b0;
        end else begin
            if (cal_valid) begin
                ref_u_q     <= ref_U;
                ref_v_q     <= ref_V;
                ref_valid_q <= 1'b1;
            end
            match_q <= match_d;
            prow_q  <= row;
            pcol_q  <= col;
            // Delayed so the pixel sharing the frame_end cycle is folded in
            // before the snapshot.
            fe_q    <= (state_q == ACCUM) && frame_end;
        end
    end

    // ---------------- accumulation ----------------
    // Sums freeze together with the count once it saturates.
    assign acc_en = (state_q == ACCUM) && match_q && (acc_cnt_q != CNT_MAX);

    always_comb begin
        acc_cnt_d = acc_cnt_q;
        srow_d    = srow_q;
        scol_d    = scol_q;
        if (state_q == DONE) begin
            acc_cnt_d = '0;
            srow_d    = '0;
            scol_d    = '0;
        end else if (acc_en) begin
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
            srow_d    = srow_q + SROW_W'(prow_q);
            scol_d    = scol_q + SCOL_W'(pcol_q);
        end
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (cal_valid) state_d = ACCUM;
            end
            ACCUM: begin
                // Snapshot uses the next-state accumulators so the final
                // registered pixel is included.
                if (fe_q) begin
                    if (acc_cnt_d >= CNT_W'(MIN_COUNT)) begin
                        state_d   = DIVIDE;
                        div_start = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DIVIDE: begin
                if (row_done && col_done) state_d = DONE;
            end
            DONE: begin
                state_d = ACCUM;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_cnt_q <= '0;
            srow_q    <= '0;
            scol_q    <= '0;
        end else begin
            state_q   <= state_d;
            acc_cnt_q <= acc_cnt_d;
            srow_q    <= srow_d;
            scol_q    <= scol_d;
        end
    end

    // ---------------- centroid dividers ----------------
    seq_divider #(.DW(SROW_W), .VW(CNT_W), .QW(ROW_W)) u_div_row (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (srow_d),
        .divisor  (acc_cnt_d),
        .quotient (q_row),
        .done     (row_done)
    );

    seq_divider #(.DW(SCOL_W), .VW(CNT_W), .QW(COL_W)) u_div_col (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (scol_d),
        .divisor  (acc_cnt_d),
        .quotient (q_col),
        .done     (col_done)
    );

    // Accumulators are frozen outside ACCUM, so in DONE they still hold the
    // closing frame's totals.
    assign found_now = (acc_cnt_q >= CNT_W'(MIN_COUNT));

    always_ff @(posedge clk) begin
        if (reset) begin
            result_valid_q <= 1'b0;
            found_q        <= 1'b0;
            count_q        <= '0;
            cent_row_q     <= '0;
            cent_col_q     <= '0;
        end else begin
            result_valid_q <= (state_q == DONE);
            if (state_q == DONE) begin
                found_q    <= found_now;
                count_q    <= acc_cnt_q;
                cent_row_q <= found_now ? q_row : '0;
                cent_col_q <= found_now ? q_col : '0;
            end
        end
    end

    // ---------------- optional bounding box ----------------
`ifdef TRACK_BBOX_EN
    logic [ROW_W-1:0] bmin_row_q, bmin_row_d, bmax_row_q, bmax_row_d;
    logic [COL_W-1:0] bmin_col_q, bmin_col_d, bmax_col_q, bmax_col_d;
    logic [ROW_W-1:0] min_row_q, max_row_q;
    logic [COL_W-1:0] min_col_q, max_col_q;

    always_comb begin
        bmin_row_d = bmin_row_q;
        bmax_row_d = bmax_row_q;
        bmin_col_d = bmin_col_q;
        bmax_col_d = bmax_col_q;
        if (state_q == DONE) begin
            bmin_row_d = '1;
            bmax_row_d = '0;
            bmin_col_d = '1;
            bmax_col_d = '0;
        end else if ((state_q == ACCUM) && match_q) begin
            if (prow_q < bmin_row_q) bmin_row_d = prow_q;
            if (prow_q > bmax_row_q) bmax_row_d = prow_q;
            if (pcol_q < bmin_col_q) bmin_col_d = pcol_q;
            if (pcol_q > bmax_col_q) bmax_col_d = pcol_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bmin_row_q <= '1;
            bmax_row_q <= '0;
            bmin_col_q <= '1;
            bmax_col_q <= '0;
            min_row_q  <= '0;
            max_row_q  <= '0;
            min_col_q  <= '0;
            max_col_q  <= '0;
        end else begin
            bmin_row_q <= bmin_row_d;
            bmax_row_q <= bmax_row_d;
            bmin_col_q <= bmin_col_d;
            bmax_col_q <= bmax_col_d;
            if (state_q == DONE) begin
                min_row_q <= found_now ? bmin_row_q : '0;
                max_row_q <= found_now ? bmax_row_q : '0;
                min_col_q <= found_now ? bmin_col_q : '0;
                max_col_q <= found_now ? bmax_col_q : '0;
            end
        end
    end

    assign min_row = min_row_q;
    assign max_row = max_row_q;
    assign min_col = min_col_q;
    assign max_col = max_col_q;
`else
    assign min_row = '0;
    assign max_row = '0;
    assign min_col = '0;
    assign max_col = '0;
`endif

    assign match        = match_q;
    assign busy         = (state_q == DIVIDE);
    assign result_valid = result_valid_q;
    assign found        = found_q;
    assign count        = count_q;
    assign cent_row     = cent_row_q;
    assign cent_col     = cent_col_q;

endmodule

// File: tb/tb_color_tracker.sv
// -----------------------------------------------------------------------------
// tb_color_tracker
// Two tracker instances share one stimulus stream: instance 0 uses the
// default MIN_COUNT of 16, instance 1 uses MIN_COUNT=1 so the single-pixel
// centroid case produces a real division. Expected frame results come from a
// queue of matched coordinates and plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_color_tracker;
    import color_tracker_pkg::*;

    localparam int ROW_W   = 13;
    localparam int COL_W   = 13;
    localparam int CNT_W   = 21;
    localparam int DIV_CYC = ROW_W + CNT_W;
`ifdef TRACK_BBOX_EN
    localparam bit BBOX_EN = 1'b1;
`else
    localparam bit BBOX_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                cal_valid = 1'b0;
    logic [7:0]          ref_Y = '0;
    logic signed [8:0]   ref_U = '0;
    logic signed [8:0]   ref_V = '0;
    logic [7:0]          tol_uv = '0;
    logic [7:0]          y_min = '0;
    logic                pix_valid = 1'b0;
    logic [7:0]          Y_in = '0;
    logic signed [8:0]   U_in = '0;
    logic signed [8:0]   V_in = '0;
    logic [ROW_W-1:0]    row = '0;
    logic [COL_W-1:0]    col = '0;
    logic                frame_end = 1'b0;

    logic                match_o [2];
    logic                busy_o [2];
    logic                rv_o [2];
    logic                found_o [2];
    logic [CNT_W-1:0]    count_o [2];
    logic [ROW_W-1:0]    crow_o [2];
    logic [COL_W-1:0]    ccol_o [2];
    logic [ROW_W-1:0]    minr_o [2];
    logic [ROW_W-1:0]    maxr_o [2];
    logic [COL_W-1:0]    minc_o [2];
    logic [COL_W-1:0]    maxc_o [2];

    always #5 clk = ~clk;

    color_tracker #(.ROW_W(ROW_W), .COL_W(COL_W), .CNT_W(CNT_W), .MIN_COUNT(16)) dut (
        .clk(clk), .reset(reset), .cal_valid(cal_valid), .ref_Y(ref_Y), .ref_U(ref_U),
        .ref_V(ref_V), .tol_uv(tol_uv), .y_min(y_min), .pix_valid(pix_valid), .Y_in(Y_in),
        .U_in(U_in), .V_in(V_in), .row(row), .col(col), .frame_end(frame_end),
        .match(match_o[0]), .busy(busy_o[0]), .result_valid(rv_o[0]), .found(found_o[0]),
        .count(count_o[0]), .cent_row(crow_o[0]), .cent_col(ccol_o[0]),
        .min_row(minr_o[0]), .max_row(maxr_o[0]), .min_col(minc_o[0]), .max_col(maxc_o[0])
    );

    color_tracker #(.ROW_W(ROW_W), .COL_W(COL_W), .CNT_W(CNT_W), .MIN_COUNT(1)) dut1 (
        .clk(clk), .reset(reset), .cal_valid(cal_valid), .ref_Y(ref_Y), .ref_U(ref_U),
        .ref_V(ref_V), .tol_uv(tol_uv), .y_min(y_min), .pix_valid(pix_valid), .Y_in(Y_in),
        .U_in(U_in), .V_in(V_in), .row(row), .col(col), .frame_end(frame_end),
        .match(match_o[1]), .busy(busy_o[1]), .result_valid(rv_o[1]), .found(found_o[1]),
        .count(count_o[1]), .cent_row(crow_o[1]), .cent_col(ccol_o[1]),
        .min_row(minr_o[1]), .max_row(maxr_o[1]), .min_col(minc_o[1]), .max_col(maxc_o[1])
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int mdl_ref_u = 0;
    int mdl_ref_v = 0;
    int q_row[$];
    int q_col[$];

    // Per-instance capture of one frame close
    int     cap_pulses [2];
    int     cap_lat [2];
    int     cap_busy [2];
    longint cap_found [2], cap_count [2], cap_cr [2], cap_cc [2];
    longint cap_minr [2], cap_maxr [2], cap_minc [2], cap_maxc [2];

    typedef struct {
        bit pv;
        int y;
        int u;
        int v;
        bit exp_match;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic bit mdl_match(input int y, input int u, input int v);
        int du, dv;
        du = u - mdl_ref_u;
        dv = v - mdl_ref_v;
        if (du < 0) du = -du;
        if (dv < 0) dv = -dv;
        return (du <= int'(tol_uv)) && (dv <= int'(tol_uv)) && (y >= int'(y_min));
    endfunction

    function automatic int clamp9(input int x);
        if (x < -256) return -256;
        if (x > 255) return 255;
        return x;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        cal_valid = 1'b0;
        pix_valid = 1'b0;
        frame_end = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        q_row.delete();
        q_col.delete();
    endtask

    task automatic cal(input int y, input int u, input int v);
        ref_Y = y[7:0];
        ref_U = u[8:0];
        ref_V = v[8:0];
        cal_valid = 1'b1;
        tick();
        cal_valid = 1'b0;
        mdl_ref_u = u;
        mdl_ref_v = v;
        $display("cal ref=(%0d,%0d,%0d)", y, u, v);
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s.d%0d.match", tag, d), match_o[d], 0);
            check($sformatf("%s.d%0d.busy", tag, d), busy_o[d], 0);
            check($sformatf("%s.d%0d.result_valid", tag, d), rv_o[d], 0);
            check($sformatf("%s.d%0d.found", tag, d), found_o[d], 0);
            check($sformatf("%s.d%0d.count", tag, d), count_o[d], 0);
            check($sformatf("%s.d%0d.cent_row", tag, d), crow_o[d], 0);
            check($sformatf("%s.d%0d.cent_col", tag, d), ccol_o[d], 0);
            check($sformatf("%s.d%0d.min_row", tag, d), minr_o[d], 0);
            check($sformatf("%s.d%0d.max_row", tag, d), maxr_o[d], 0);
            check($sformatf("%s.d%0d.min_col", tag, d), minc_o[d], 0);
            check($sformatf("%s.d%0d.max_col", tag, d), maxc_o[d], 0);
        end
    endtask

    // One pixel in ACCUM; optional coincident frame_end and reference reload.
    task automatic pixel(input int y, input int u, input int v, input int r, input int c,
                         input bit fe, input bit cal_en, input int nu, input int nv);
        bit exp;
        Y_in = y[7:0];
        U_in = u[8:0];
        V_in = v[8:0];
        row = r[ROW_W-1:0];
        col = c[COL_W-1:0];
        pix_valid = 1'b1;
        frame_end = fe;
        if (cal_en) begin
            ref_U = nu[8:0];
            ref_V = nv[8:0];
            cal_valid = 1'b1;
        end
        tick();
        pix_valid = 1'b0;
        frame_end = 1'b0;
        cal_valid = 1'b0;
        exp = mdl_match(y, u, v);
        check("pix.match", match_o[0], exp);
        check("pix.match1", match_o[1], exp);
        if (exp) begin
            q_row.push_back(r);
            q_col.push_back(c);
        end
        if (cal_en) begin
            mdl_ref_u = nu;
            mdl_ref_v = nv;
        end
    endtask

    task automatic fe_only();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    // Observe 60 cycles after the frame_end cycle; optionally inject a matching
    // pixel plus a stray frame_end at cycle inj_k (expected to be ignored).
    task automatic close_frame(input string tag, input int inj_k);
        int n, minc, exp_cr, exp_cc, mnr, mxr, mnc, mxc;
        longint sr, sc;
        bit f;
        for (int d = 0; d < 2; d++) begin
            cap_pulses[d] = 0; cap_lat[d] = 0; cap_busy[d] = 0;
            cap_found[d] = 0; cap_count[d] = 0; cap_cr[d] = 0; cap_cc[d] = 0;
            cap_minr[d] = 0; cap_maxr[d] = 0; cap_minc[d] = 0; cap_maxc[d] = 0;
        end
        for (int k = 1; k <= 60; k++) begin
            if (k == inj_k) begin
                Y_in = 8'd255;
                U_in = mdl_ref_u[8:0];
                V_in = mdl_ref_v[8:0];
                row = 13'd50;
                col = 13'd50;
                pix_valid = 1'b1;
                frame_end = 1'b1;
            end
            tick();
            pix_valid = 1'b0;
            frame_end = 1'b0;
            for (int d = 0; d < 2; d++) begin
                if (busy_o[d]) cap_busy[d]++;
                if (rv_o[d]) begin
                    cap_pulses[d]++;
                    cap_lat[d] = k;
                    cap_found[d] = found_o[d];
                    cap_count[d] = count_o[d];
                    cap_cr[d] = crow_o[d];
                    cap_cc[d] = ccol_o[d];
                    cap_minr[d] = minr_o[d];
                    cap_maxr[d] = maxr_o[d];
                    cap_minc[d] = minc_o[d];
                    cap_maxc[d] = maxc_o[d];
                end
            end
        end
        n = q_row.size();
        sr = 0; sc = 0;
        mnr = 8191; mxr = 0; mnc = 8191; mxc = 0;
        for (int i = 0; i < n; i++) begin
            sr += q_row[i];
            sc += q_col[i];
            if (q_row[i] < mnr) mnr = q_row[i];
            if (q_row[i] > mxr) mxr = q_row[i];
            if (q_col[i] < mnc) mnc = q_col[i];
            if (q_col[i] > mxc) mxc = q_col[i];
        end
        for (int d = 0; d < 2; d++) begin
            minc = (d == 0) ? 16 : 1;
            f = (n >= minc);
            exp_cr = f ? int'(sr / n) : 0;
            exp_cc = f ? int'(sc / n) : 0;
            check($sformatf("%s.d%0d.pulses", tag, d), cap_pulses[d], 1);
            check($sformatf("%s.d%0d.latency", tag, d), cap_lat[d], f ? 2 + DIV_CYC : 2);
            check($sformatf("%s.d%0d.busy_cycles", tag, d), cap_busy[d], f ? DIV_CYC : 0);
            check($sformatf("%s.d%0d.found", tag, d), cap_found[d], f);
            check($sformatf("%s.d%0d.count", tag, d), cap_count[d], n);
            check($sformatf("%s.d%0d.cent_row", tag, d), cap_cr[d], exp_cr);
            check($sformatf("%s.d%0d.cent_col", tag, d), cap_cc[d], exp_cc);
            check($sformatf("%s.d%0d.min_row", tag, d), cap_minr[d], (BBOX_EN && f) ? mnr : 0);
            check($sformatf("%s.d%0d.max_row", tag, d), cap_maxr[d], (BBOX_EN && f) ? mxr : 0);
            check($sformatf("%s.d%0d.min_col", tag, d), cap_minc[d], (BBOX_EN && f) ? mnc : 0);
            check($sformatf("%s.d%0d.max_col", tag, d), cap_maxc[d], (BBOX_EN && f) ? mxc : 0);
            $display("%s d%0d: n=%0d found=%0d count=%0d cent=(%0d,%0d) lat=%0d busy=%0d",
                     tag, d, n, cap_found[d], cap_count[d], cap_cr[d], cap_cc[d],
                     cap_lat[d], cap_busy[d]);
        end
        q_row.delete();
        q_col.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[8];
        int   busy_seen, rv_seen, nfr, y, u, v, r, c, nu, nv;
        bit   fe, ce;

        tv[0] = '{1, 120, 25, -35, 1};
        tv[1] = '{1, 120, 31, -30, 0};
        tv[2] = '{1, 40, 20, -30, 0};
        tv[3] = '{1, 50, 30, -40, 1};
        tv[4] = '{1, 49, 20, -30, 0};
        tv[5] = '{0, 120, 20, -30, 0};
        tv[6] = '{1, 255, 10, -20, 1};
        tv[7] = '{1, 120, 9, -30, 0};

        tol_uv = 8'd10;
        y_min  = 8'd50;
        do_reset();
        check_zero("reset");

        // ---- 1: classification table ----
        cal(100, 20, -30);
        for (int i = 0; i < 8; i++) begin
            Y_in = tv[i].y[7:0];
            U_in = tv[i].u[8:0];
            V_in = tv[i].v[8:0];
            pix_valid = tv[i].pv;
            tick();
            pix_valid = 1'b0;
            check($sformatf("t1.v%0d.match", i), match_o[0], tv[i].exp_match);
            $display("t1 vec%0d pv=%0d Y=%0d U=%0d V=%0d match=%0d", i, tv[i].pv,
                     tv[i].y, tv[i].u, tv[i].v, match_o[0]);
        end

        // ---- 2: 20 pixels, found ----
        do_reset();
        cal(100, 20, -30);
        for (int i = 0; i < 20; i++) pixel(120, 25, -35, 10 + i, 40, 0, 0, 0, 0);
        fe_only();
        close_frame("t2", 0);

        // ---- 3: 10 pixels, not found on instance 0 ----
        for (int i = 0; i < 10; i++) pixel(120, 25, -35, 300 + i, 600 + i, 0, 0, 0, 0);
        fe_only();
        close_frame("t3", 0);

        // ---- 4: pixel coincident with frame_end; pixel during busy ignored ----
        for (int i = 0; i < 16; i++) pixel(120, 25, -35, 100 + i, 200, 0, 0, 0, 0);
        pixel(120, 25, -35, 5, 7, 1, 0, 0, 0);
        close_frame("t4", 5);
        fe_only();
        close_frame("t4next", 0);

        // ---- 5: reset during DIVIDE ----
        for (int i = 0; i < 20; i++) pixel(120, 25, -35, 10 + i, 40, 0, 0, 0, 0);
        fe_only();
        for (int i = 0; i < 10; i++) tick();
        check("t5.busy_before_reset", busy_o[0], 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q_row.delete();
        q_col.delete();
        check_zero("t5.after_reset");
        busy_seen = 0;
        rv_seen = 0;
        for (int k = 0; k < 50; k++) begin
            if (k == 5 || k == 20) begin
                Y_in = 8'd120; U_in = 9'sd25; V_in = -9'sd35;
                pix_valid = 1'b1;
                frame_end = 1'b1;
            end
            tick();
            pix_valid = 1'b0;
            frame_end = 1'b0;
            if (busy_o[0] || busy_o[1]) busy_seen++;
            if (rv_o[0] || rv_o[1]) rv_seen++;
        end
        check("t5.result_valid_pulses", rv_seen, 0);
        check("t5.busy_cycles", busy_seen, 0);
        check("t5.match_idle", match_o[0], 0);
        $display("t5 reset mid-divide: rv=%0d busy=%0d", rv_seen, busy_seen);

        // ---- 6: single pixel, exact divide by 1 ----
        cal(100, 20, -30);
        pixel(120, 25, -35, 1079, 1919, 0, 0, 0, 0);
        fe_only();
        close_frame("t6", 0);

        // ---- randomized frames against the reference model ----
        for (int f = 0; f < 10; f++) begin
            tol_uv = 8'($urandom_range(0, 40));
            y_min  = 8'($urandom_range(0, 120));
            if (f % 4 == 0) cal(100, $urandom_range(0, 511) - 256, $urandom_range(0, 511) - 256);
            nfr = $urandom_range(0, 28);
            fe = 1'b0;
            for (int i = 0; i < nfr; i++) begin
                y = $urandom_range(0, 255);
                if ($urandom_range(0, 3) != 0) begin
                    u = clamp9(mdl_ref_u + $urandom_range(0, 2 * int'(tol_uv) + 6) - int'(tol_uv) - 3);
                    v = clamp9(mdl_ref_v + $urandom_range(0, 2 * int'(tol_uv) + 6) - int'(tol_uv) - 3);
                end else begin
                    u = $urandom_range(0, 511) - 256;
                    v = $urandom_range(0, 511) - 256;
                end
                r = $urandom_range(0, 1079);
                c = $urandom_range(0, 1919);
                fe = (i == nfr - 1) && ($urandom_range(0, 1) == 1);
                ce = ($urandom_range(0, 9) == 0);
                nu = clamp9(mdl_ref_u + $urandom_range(0, 20) - 10);
                nv = clamp9(mdl_ref_v + $urandom_range(0, 20) - 10);
                pixel(y, u, v, r, c, fe, ce, nu, nv);
            end
            if (!fe) fe_only();
            close_frame($sformatf("rnd%0d", f), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
